// File: rtl/sdrc_app_pkg.sv
// Shared types and default widths for the sdrc_core application-side sequencer.
package sdrc_app_pkg;

   localparam int AW_DEFAULT = 30;
   localparam int LW_DEFAULT = 9;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_DATA,
      REQ,
      WR_XFER,
      RD_XFER
   } state_e;

endpackage

// File: rtl/sdrc_app_fifo.sv
// Show-ahead write-data FIFO: the head word is visible on rdata_o without a read strobe.
module sdrc_app_fifo #(
   parameter  int DW     = 32,
   parameter  int WDEPTH = 64,
   localparam int PW     = $clog2(WDEPTH),
   localparam int CW     = PW + 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          push_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          pop_i,
   output logic [DW-1:0] rdata_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);

   logic [DW-1:0] mem_q [WDEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count_q == CW'(WDEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Pointers wrap naturally because WDEPTH is a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/sdrc_app_seq.sv
// Request sequencer in front of sdrc_core: turns a command stream plus buffered
// write data into single outstanding core requests and registers read returns.
module sdrc_app_seq
   import sdrc_app_pkg::*;
#(
   parameter  int DW     = 32,
   parameter  int AW     = AW_DEFAULT,
   parameter  int LW     = LW_DEFAULT,
   parameter  int WDEPTH = 64,
   localparam int CW     = $clog2(WDEPTH) + 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [AW-1:0]   cmd_addr,
   input  logic [LW-1:0]   cmd_len,
   input  logic            cmd_wr_n,
   input  logic            wd_valid,
   output logic            wd_ready,
   input  logic [DW-1:0]   wd_data,
   output logic [DW-1:0]   rd_data,
   output logic            rd_valid,
   output logic            rd_last,
   output logic            busy,
   output logic            err_len,
   output logic            app_req,
   output logic [AW-1:0]   app_req_addr,
   output logic [LW-1:0]   app_req_len,
   output logic            app_req_wr_n,
   input  logic            app_req_ack,
   output logic [DW-1:0]   app_wr_data,
   output logic [DW/8-1:0] app_wr_en_n,
   input  logic            app_wr_next_req,
   input  logic            app_rd_valid,
   input  logic [DW-1:0]   app_rd_data,
   input  logic            app_last_rd
);

   state_e          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [LW-1:0]   len_q, len_d;
   logic            wr_n_q, wr_n_d;
   logic [LW-1:0]   beat_q, beat_d;
   logic            err_q, err_d;
   logic            app_req_q;
   logic [DW-1:0]   rd_data_q, rd_data_d;
   logic            rd_valid_q, rd_valid_d;
   logic            rd_last_q, rd_last_d;
   logic [CW-1:0]   fifo_count;
   logic            fifo_full;
   logic            fifo_empty;
   logic            fifo_pop;

   assign fifo_pop = app_wr_next_req && (state_q == WR_XFER);

   sdrc_app_fifo #(
      .DW     (DW),
      .WDEPTH (WDEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (wd_valid),
      .wdata_i (wd_data),
      .pop_i   (fifo_pop),
      .rdata_o (app_wr_data),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      len_d      = len_q;
      wr_n_d     = wr_n_q;
      beat_d     = beat_q;
      err_d      = err_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               addr_d = cmd_addr;
               len_d  = cmd_len;
               wr_n_d = cmd_wr_n;
               beat_d = '0;
               // Oversized writes could never become resident, so they are refused here.
               if (cmd_len == '0) begin
                  state_d = IDLE;
               end else if (!cmd_wr_n && (32'(cmd_len) > 32'(WDEPTH))) begin
                  err_d = 1'b1;
               end else begin
                  state_d = cmd_wr_n ? REQ : WAIT_DATA;
               end
            end
         end
         WAIT_DATA: begin
            if (32'(fifo_count) >= 32'(len_q)) state_d = REQ;
         end
         REQ: begin
            if (app_req_ack) state_d = wr_n_q ? RD_XFER : WR_XFER;
         end
         WR_XFER: begin
            if (fifo_pop) begin
               beat_d = beat_q + LW'(1);
               if (beat_d == len_q) state_d = IDLE;
            end
         end
         RD_XFER: begin
            if (app_rd_valid) begin
               beat_d     = beat_q + LW'(1);
               rd_valid_d = 1'b1;
               rd_data_d  = app_rd_data;
               rd_last_d  = (beat_d == len_q) || app_last_rd;
               if (rd_last_d) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         wr_n_q     <= 1'b1;
         beat_q     <= '0;
         err_q      <= 1'b0;
         app_req_q  <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         wr_n_q     <= wr_n_d;
         beat_q     <= beat_d;
         err_q      <= err_d;
         app_req_q  <= (state_d == REQ);
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         rd_last_q  <= rd_last_d;
      end
   end

   assign cmd_ready    = (state_q == IDLE);
   assign wd_ready     = ~fifo_full;
   assign busy         = (state_q != IDLE);
   assign err_len      = err_q;
   assign app_req      = app_req_q;
   assign app_req_addr = addr_q;
   assign app_req_len  = len_q;
   assign app_req_wr_n = wr_n_q;
   assign app_wr_en_n  = (state_q == WR_XFER) ? '0 : '1;
   assign rd_data      = rd_data_q;
   assign rd_valid     = rd_valid_q;
   assign rd_last      = rd_last_q;

   // The whole burst is resident before the request, so the core can never pull from an empty FIFO.
   a_no_pop_when_empty : assert property (@(posedge clk) disable iff (!reset_n)
      !(fifo_pop && fifo_empty));

endmodule

// File: tb/tb_sdrc_app_seq.sv
// Directed bench for sdrc_app_seq with queue scoreboards for write and read data.
module tb_sdrc_app_seq;

   logic        clk;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [29:0] cmd_addr;
   logic [8:0]  cmd_len;
   logic        cmd_wr_n;
   logic        wd_valid;
   logic        wd_ready;
   logic [31:0] wd_data;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        rd_last;
   logic        busy;
   logic        err_len;
   logic        app_req;
   logic [29:0] app_req_addr;
   logic [8:0]  app_req_len;
   logic        app_req_wr_n;
   logic        app_req_ack;
   logic [31:0] app_wr_data;
   logic [3:0]  app_wr_en_n;
   logic        app_wr_next_req;
   logic        app_rd_valid;
   logic [31:0] app_rd_data;
   logic        app_last_rd;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] wq [$];
   logic [32:0] rq [$];

   sdrc_app_seq #(.DW(32), .AW(30), .LW(9), .WDEPTH(64)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_addr        (cmd_addr),
      .cmd_len         (cmd_len),
      .cmd_wr_n        (cmd_wr_n),
      .wd_valid        (wd_valid),
      .wd_ready        (wd_ready),
      .wd_data         (wd_data),
      .rd_data         (rd_data),
      .rd_valid        (rd_valid),
      .rd_last         (rd_last),
      .busy            (busy),
      .err_len         (err_len),
      .app_req         (app_req),
      .app_req_addr    (app_req_addr),
      .app_req_len     (app_req_len),
      .app_req_wr_n    (app_req_wr_n),
      .app_req_ack     (app_req_ack),
      .app_wr_data     (app_wr_data),
      .app_wr_en_n     (app_wr_en_n),
      .app_wr_next_req (app_wr_next_req),
      .app_rd_valid    (app_rd_valid),
      .app_rd_data     (app_rd_data),
      .app_last_rd     (app_last_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_word(input logic [31:0] d);
      wd_valid = 1'b1;
      wd_data  = d;
      if (wd_ready) wq.push_back(d);
      step();
      wd_valid = 1'b0;
   endtask

   task automatic send_cmd(input logic [29:0] a, input logic [8:0] l, input logic wn);
      int t = 0;
      while (!cmd_ready && t < 50) begin
         step();
         t++;
      end
      check("cmd_ready_wait", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_len   = l;
      cmd_wr_n  = wn;
      step();
      cmd_valid = 1'b0;
   endtask

   // Waits for the request, checks it stays up until acked, then acks it.
   task automatic wait_req(input logic [29:0] a, input logic [8:0] l, input logic wn);
      int t = 0;
      while (!app_req && t < 50) begin
         step();
         t++;
      end
      check("app_req_seen", app_req, 1);
      check("app_req_addr", app_req_addr, a);
      check("app_req_len", app_req_len, l);
      check("app_req_wr_n", app_req_wr_n, wn);
      step();
      check("app_req_held", app_req, 1);
      app_req_ack = 1'b1;
      step();
      app_req_ack = 1'b0;
      check("app_req_dropped", app_req, 0);
      check("busy_xfer", busy, 1);
   endtask

   task automatic wr_burst(input int n, input bit push_during, input logic [31:0] pbase);
      for (int i = 0; i < n; i++) begin
         check("wr_en_active", app_wr_en_n, 4'h0);
         check("fifo_count", dut.u_fifo.count_o, wq.size());
         if (wq.size() == 0) begin
            n_fail++;
            $error("FAIL wq_empty: observed 0 entries expected >0");
         end else begin
            check("wr_data", app_wr_data, wq.pop_front());
         end
         if (push_during && i > 0) begin
            wd_valid = 1'b1;
            wd_data  = pbase + 32'(i);
            if (wd_ready) wq.push_back(wd_data);
         end
         app_wr_next_req = 1'b1;
         step();
         app_wr_next_req = 1'b0;
         wd_valid        = 1'b0;
      end
   endtask

   task automatic rd_burst(input int len, input int last_at, input logic [31:0] base);
      logic [32:0] e;
      logic        lst;
      for (int i = 0; i < len; i++) begin
         lst          = (i == len - 1) || (i == last_at);
         app_rd_valid = 1'b1;
         app_rd_data  = base + 32'(i);
         app_last_rd  = (i == last_at);
         rq.push_back({lst, base + 32'(i)});
         step();
         app_rd_valid = 1'b0;
         app_last_rd  = 1'b0;
         check("rd_valid", rd_valid, 1);
         e = rq.pop_front();
         check("rd_data", rd_data, e[31:0]);
         check("rd_last", rd_last, e[32]);
         if (lst) break;
         if (i % 2 == 1) begin
            step();
            check("rd_valid_gap", rd_valid, 0);
         end
      end
      check("rd_busy_end", busy, 0);
   endtask

   initial begin
      reset_n = 1'b0;
      cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_wr_n = 1'b1;
      wd_valid = 1'b0; wd_data = '0;
      app_req_ack = 1'b0; app_wr_next_req = 1'b0;
      app_rd_valid = 1'b0; app_rd_data = '0; app_last_rd = 1'b0;
      step();
      step();
      check("rst_app_req", app_req, 0);
      check("rst_addr", app_req_addr, 0);
      check("rst_len", app_req_len, 0);
      check("rst_wr_n", app_req_wr_n, 1);
      check("rst_wr_en_n", app_wr_en_n, 4'hF);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_last", rd_last, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_err_len", err_len, 0);
      check("rst_busy", busy, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_wd_ready", wd_ready, 1);
      reset_n = 1'b1;
      step();

      // Write of 4 with all data resident.
      for (int i = 0; i < 4; i++) push_word(32'hA000_0000 + 32'(i));
      send_cmd(30'h10000, 9'd4, 1'b0);
      wait_req(30'h10000, 9'd4, 1'b0);
      wr_burst(4, 1'b0, 32'h0);
      check("w4_busy_done", busy, 0);
      check("w4_wr_en_idle", app_wr_en_n, 4'hF);

      // Write of 5 waits for data.
      for (int i = 0; i < 3; i++) push_word(32'hB000_0000 + 32'(i));
      send_cmd(30'h200, 9'd5, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("w5_req_blocked", app_req, 0);
      end
      push_word(32'hB000_0003);
      push_word(32'hB000_0004);
      check("w5_req_not_yet", app_req, 0);
      step();
      check("w5_req_next", app_req, 1);
      wait_req(30'h200, 9'd5, 1'b0);
      wr_burst(5, 1'b0, 32'h0);
      check("w5_busy_done", busy, 0);

      // Reads: full length, then early termination by app_last_rd.
      send_cmd(30'h100000, 9'd5, 1'b1);
      wait_req(30'h100000, 9'd5, 1'b1);
      rd_burst(5, 4, 32'hD000_0000);
      send_cmd(30'h3000, 9'd8, 1'b1);
      wait_req(30'h3000, 9'd8, 1'b1);
      rd_burst(8, 3, 32'hE000_0000);

      // Oversized write and zero-length command are dropped.
      send_cmd(30'h40, 9'd65, 1'b0);
      check("err_set", err_len, 1);
      check("err_busy", busy, 0);
      check("err_cmd_ready", cmd_ready, 1);
      check("err_no_req", app_req, 0);
      step();
      check("err_no_req_later", app_req, 0);
      send_cmd(30'h50, 9'd0, 1'b1);
      check("len0_busy", busy, 0);
      step();
      check("len0_no_req", app_req, 0);
      check("err_sticky", err_len, 1);

      // Fill to depth, overlap push/pop, then drain across pointer wrap.
      for (int i = 0; i < 64; i++) push_word(32'hC000_0000 + 32'(i));
      check("full_wd_ready", wd_ready, 0);
      check("full_count", dut.u_fifo.count_o, 64);
      push_word(32'hDEAD_BEEF);
      check("full_count_hold", dut.u_fifo.count_o, wq.size());
      send_cmd(30'h800, 9'd64, 1'b0);
      wait_req(30'h800, 9'd64, 1'b0);
      wr_burst(64, 1'b1, 32'hF000_0000);
      check("ovl_busy_done", busy, 0);
      check("ovl_count", dut.u_fifo.count_o, wq.size());
      send_cmd(30'h900, 9'd63, 1'b0);
      wait_req(30'h900, 9'd63, 1'b0);
      wr_burst(63, 1'b0, 32'h0);
      check("drain_count", dut.u_fifo.count_o, 0);
      check("drain_busy", busy, 0);

      // Reset in the middle of a write burst.
      for (int i = 0; i < 6; i++) push_word(32'h6000_0000 + 32'(i));
      send_cmd(30'hA00, 9'd6, 1'b0);
      wait_req(30'hA00, 9'd6, 1'b0);
      wr_burst(2, 1'b0, 32'h0);
      check("mid_busy", busy, 1);
      #2;
      reset_n = 1'b0;
      #2;
      wq.delete();
      check("mr_busy", busy, 0);
      check("mr_wr_en_n", app_wr_en_n, 4'hF);
      check("mr_app_req", app_req, 0);
      check("mr_wr_n", app_req_wr_n, 1);
      check("mr_len", app_req_len, 0);
      check("mr_err_len", err_len, 0);
      check("mr_count", dut.u_fifo.count_o, 0);
      check("mr_wd_ready", wd_ready, 1);
      step();
      reset_n = 1'b1;
      step();
      push_word(32'h7000_0000);
      push_word(32'h7000_0001);
      send_cmd(30'hB00, 9'd2, 1'b0);
      wait_req(30'hB00, 9'd2, 1'b0);
      wr_burst(2, 1'b0, 32'h0);
      check("post_busy", busy, 0);
      send_cmd(30'hC00, 9'd1, 1'b1);
      wait_req(30'hC00, 9'd1, 1'b1);
      rd_burst(1, 0, 32'h8000_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/sdrc_app_seq.md
Name: sdrc_app_seq

Overview:
- Application-side request sequencer placed directly upstream of sdrc_core. It drives the app_req/app_req_ack request handshake, app_wr_next_req write-data pull and app_rd_valid read-return interfaces.
- It converts a simple valid/ready command stream and a valid/ready write-data stream into correctly timed core requests.
- Write data is buffered in a show-ahead FIFO. A write request is issued only when the whole burst is resident, so the core never stalls on missing data.
- Read data is registered and returned with a last-beat flag.

Parameters:
- DW, 32, data width; equals the app_wr_data/app_rd_data width of sdrc_core.
- AW, 30, application address width (word address).
- LW, 9, burst length width; matches app_req_len.
- WDEPTH, 64, write FIFO depth in words; power of 2, >= 2.

Ports:
- clk  in  1  system clock, same as sdrc_core clk.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_addr  in  AW  start word address.
- cmd_len  in  LW  burst length in words.
- cmd_wr_n  in  1  0 = write, 1 = read.
- wd_valid  in  1  write word offered.
- wd_ready  out  1  FIFO not full.
- wd_data  in  DW  write word.
- rd_data  out  DW  returned read word.
- rd_valid  out  1  rd_data qualifier.
- rd_last  out  1  last word of read burst.
- busy  out  1  state != IDLE.
- err_len  out  1  sticky; a write command had cmd_len > WDEPTH. Cleared only by reset.
- app_req  out  1  request to core.
- app_req_addr  out  AW  request address.
- app_req_len  out  LW  request length.
- app_req_wr_n  out  1  request direction.
- app_req_ack  in  1  core accepted request.
- app_wr_data  out  DW  FIFO head word (show-ahead).
- app_wr_en_n  out  DW/8  byte enables, active low.
- app_wr_next_req  in  1  core consumes current app_wr_data.
- app_rd_valid  in  1  core read word valid.
- app_rd_data  in  DW  core read word.
- app_last_rd  in  1  core last read word.

Behaviour:
- Reset (asynchronous, active-low):
  - State IDLE; FIFO empty.
  - app_req = 0; app_req_addr = 0; app_req_len = 0; app_req_wr_n = 1.
  - app_wr_en_n = all 1s.
  - rd_valid = 0; rd_last = 0; rd_data = 0; err_len = 0; busy = 0.
  - Reset mid-burst abandons the burst and discards all buffered data.
- cmd_ready = (state == IDLE). On accept, addr/len/wr_n are latched into the app_req_* registers.
- Accept routing:
  - cmd_len == 0: command is dropped, state stays IDLE.
  - Write with cmd_len > WDEPTH: err_len is set, command is dropped, state stays IDLE.
  - Otherwise: write -> WAIT_DATA; read -> REQ.
- WAIT_DATA: move to REQ in the cycle after the FIFO count >= latched len.
- REQ:
  - app_req = 1; app_req_* held stable.
  - On the clk edge where app_req_ack = 1, app_req is deasserted next cycle.
  - Next state is WR_XFER for a write, RD_XFER for a read.
- WR_XFER:
  - app_wr_en_n = all 0s.
  - app_wr_data = FIFO head, combinational.
  - Each cycle with app_wr_next_req = 1 pops one word and increments the beat counter.
  - When counter == len: app_wr_en_n returns to all 1s, state -> IDLE.
  - app_wr_next_req while the FIFO is empty is impossible by construction; an assertion fires if it occurs.
- RD_XFER:
  - rd_data/rd_valid/rd_last are registered copies of app_rd_data/app_rd_valid (1-cycle latency).
  - rd_last = 1 when the beat is the len-th, or when app_last_rd is high on that beat.
  - State -> IDLE after that beat.
  - No backpressure on the read return; the consumer must always accept.
- FIFO:
  - Push when wd_valid & wd_ready, in any state.
  - Push and pop in the same cycle leave the count unchanged.
  - Count width is clog2(WDEPTH)+1; pointers wrap modulo WDEPTH.
  - wd_ready = count < WDEPTH.
- Only one request is outstanding at a time; a new command is not accepted until the previous burst completes.

Decomposition:
- Package sdrc_app_pkg holds:
  - the state enum (IDLE, WAIT_DATA, REQ, WR_XFER, RD_XFER);
  - default widths AW = 30, LW = 9.
- One sub-module, sdrc_app_fifo: synchronous show-ahead FIFO with WDEPTH and DW parameters, outputs count/full/empty, asynchronous active-low reset.

Test Plan:
- Push 4 words A0..A3, then write cmd addr 0x10000, len 4 -> one app_req pulse held until ack; app_req_len = 4; app_wr_data = A0..A3 on successive next_req; FIFO empty; busy falls after 4th pop.
- Write cmd len 5 with only 3 words pushed -> app_req stays 0. After 2 more pushes -> app_req asserts the cycle after count reaches 5.
- Read cmd addr 0x100000, len 5; core returns D0..D4 -> rd_valid 5 pulses, rd_data = D0..D4 each 1 cycle after app_rd_valid, rd_last only with D4.
- Write cmd len 65 with WDEPTH = 64 -> err_len = 1, no app_req, cmd_ready back high. cmd len 0 -> silently dropped.
- Fill FIFO to 64 -> wd_ready = 0. Simultaneous push and pop during WR_XFER -> count constant. Pointer wrap after 100+ words -> data order preserved.
- Assert reset_n = 0 during WR_XFER after 2 of 6 beats -> all outputs return to reset values immediately, FIFO empty; next command behaves normally.
